// File: rtl/term_line_write_ctrl_if.sv
// rtl/term_line_write_ctrl_if.sv - keyboard, line-buffer and frame-logic signals of the line write sequencer
interface term_line_write_ctrl_if #(
    parameter int CW = 6
);
    logic          char_valid;
    logic [6:0]    char_data;
    logic          char_ready;
    logic          clr_req;
    logic          sr_shift;
    logic          sr_rc;
    logic [CW-1:0] sr_din;
    logic          line_adv;
    logic          line_done;
    logic [5:0]    cursor_col;
    logic          cursor_here;
    logic          busy;

    modport master (
        output char_valid, char_data, clr_req, sr_shift, line_done,
        input  char_ready, sr_rc, sr_din, line_adv, cursor_col, cursor_here, busy
    );

    modport slave (
        input  char_valid, char_data, clr_req, sr_shift, line_done,
        output char_ready, sr_rc, sr_din, line_adv, cursor_col, cursor_here, busy
    );
endinterface

// File: rtl/term_line_write_ctrl.sv
// rtl/term_line_write_ctrl.sv - write sequencer for the recirculating 40-character line buffer
module term_line_write_ctrl #(
    parameter int            COLS  = 40,
    parameter int            CW    = 6,
    parameter logic [CW-1:0] SPACE = 6'h20
) (
    input  logic                  clk,
    input  logic                  reset,
    term_line_write_ctrl_if.slave bus
);
    localparam logic [5:0] LAST = 6'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_POS,
        NEWLINE,
        WAIT_ACK,
        CLEAR
    } state_t;

    state_t        state_q;
    logic [5:0]    pos_q;
    logic [5:0]    cursor_col_q;
    logic [5:0]    clr_cnt_q;
    logic          clr_pend_q;
    logic [CW-1:0] char_reg_q;
    logic          line_adv_q;

    logic [5:0]    pos_d;
    logic          at_cursor;
    logic          accept;
    logic          is_cr;
    logic          is_ctrl;
    logic [CW-1:0] char_code_d;

    // pos mirrors the buffer tap and must keep counting whatever the sequencer is doing
    assign pos_d     = bus.sr_shift ? ((pos_q == LAST) ? 6'd0 : pos_q + 6'd1) : pos_q;
    assign at_cursor = (pos_q == cursor_col_q);

    assign bus.char_ready = (state_q == IDLE) && !clr_pend_q && !bus.clr_req;
    assign accept         = bus.char_valid && bus.char_ready;
    assign is_cr          = (bus.char_data == 7'h0D);
    assign is_ctrl        = (bus.char_data < 7'h20);

    // lower-case letters fold onto the upper-case codes the character ROM holds
    assign char_code_d = bus.char_data[CW-1:0] - ((bus.char_data >= 7'h60) ? CW'(6'h20) : CW'(6'h00));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pos_q        <= 6'd0;
            cursor_col_q <= 6'd0;
            clr_cnt_q    <= 6'd0;
            clr_pend_q   <= 1'b0;
            char_reg_q   <= '0;
            line_adv_q   <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            line_adv_q <= 1'b0;

            if (bus.clr_req && (state_q != IDLE)) begin
                clr_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.clr_req || clr_pend_q) begin
                        state_q      <= CLEAR;
                        clr_pend_q   <= 1'b0;
                        clr_cnt_q    <= 6'd0;
                        cursor_col_q <= 6'd0;
                    end else if (accept) begin
                        if (is_cr) begin
                            state_q    <= NEWLINE;
                            line_adv_q <= 1'b1;
                        end else if (!is_ctrl) begin
                            char_reg_q <= char_code_d;
                            state_q    <= WAIT_POS;
                        end
                    end
                end

                WAIT_POS: begin
                    if (bus.sr_shift && at_cursor) begin
                        if (cursor_col_q == LAST) begin
                            state_q    <= NEWLINE;
                            line_adv_q <= 1'b1;
                        end else begin
                            cursor_col_q <= cursor_col_q + 6'd1;
                            state_q      <= IDLE;
                        end
                    end
                end

                NEWLINE: begin
                    state_q <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (bus.line_done) begin
                        cursor_col_q <= 6'd0;
                        state_q      <= IDLE;
                    end
                end

                CLEAR: begin
                    // one full revolution of the buffer overwrites every column exactly once
                    if (bus.sr_shift) begin
                        if (clr_cnt_q == LAST) begin
                            state_q <= IDLE;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 6'd1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.sr_rc  = 1'b0;
        bus.sr_din = char_reg_q;
        case (state_q)
            WAIT_POS: begin
                bus.sr_rc = at_cursor;
            end
            CLEAR: begin
                bus.sr_rc  = 1'b1;
                bus.sr_din = SPACE;
            end
            default: begin
                bus.sr_rc = 1'b0;
            end
        endcase
    end

    assign bus.line_adv    = line_adv_q;
    assign bus.cursor_col  = cursor_col_q;
    assign bus.cursor_here = at_cursor;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_term_line_write_ctrl.sv
// tb/tb_term_line_write_ctrl.sv - scoreboard bench for the line write sequencer
module tb_term_line_write_ctrl;
    localparam int COLS  = 40;
    localparam int SPACE = 32;

    typedef struct {
        int         col;
        logic [5:0] code;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    term_line_write_ctrl_if bus ();

    term_line_write_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wr_t exp_wr[$];
    int  exp_adv_q[$];
    int  checks    = 0;
    int  errors    = 0;
    int  tb_pos    = 0;
    int  m_cursor  = 0;
    int  shift_pct = 100;
    bit  auto_ack  = 1'b1;
    bit  man_done  = 1'b0;
    int  ack_delay = -1;
    int  clr_hits[COLS];
    wr_t mon_e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int n_clear();
        int n = 0;
        foreach (exp_wr[i]) if (exp_wr[i].col < 0) n++;
        return n;
    endfunction

    task automatic push_clear();
        for (int i = 0; i < COLS; i++) exp_wr.push_back('{col: -1, code: 6'h20});
        for (int i = 0; i < COLS; i++) clr_hits[i] = 0;
        m_cursor = 0;
    endtask

    task automatic chk_hits(input string name);
        int bad = 0;
        for (int i = 0; i < COLS; i++) if (clr_hits[i] != 1) bad++;
        chk(name, bad, 0);
    endtask

    // reference: what a character does to the line, in terms of columns and codes
    task automatic model_char(input logic [6:0] c);
        logic [6:0] f;
        if (c == 7'h0D) begin
            exp_adv_q.push_back(1);
            m_cursor = 0;
        end else if (c >= 7'h20) begin
            f = (c >= 7'h60) ? c - 7'h20 : c;
            exp_wr.push_back('{col: m_cursor, code: f[5:0]});
            if (m_cursor == COLS - 1) begin
                exp_adv_q.push_back(1);
                m_cursor = 0;
            end else begin
                m_cursor++;
            end
        end
    endtask

    task automatic send(input logic [6:0] c);
        int n = 0;
        while (!bus.char_ready && n < 3000) begin
            cyc();
            n++;
        end
        checks++;
        if (!bus.char_ready) begin
            errors++;
            $display("FAIL ready_timeout: char_ready=0 after %0d cycles, required 1", n);
        end
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        cyc();
        bus.char_valid = 1'b0;
        model_char(c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || exp_wr.size() != 0 || exp_adv_q.size() != 0) && n < 5000) begin
            cyc();
            n++;
        end
        checks++;
        if (bus.busy || exp_wr.size() != 0 || exp_adv_q.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0d writes_left=%0d adv_left=%0d, required 0 0 0",
                     bus.busy, exp_wr.size(), exp_adv_q.size());
        end
        chk("cursor_col", int'(bus.cursor_col), m_cursor);
        chk("cursor_here", int'(bus.cursor_here), int'(tb_pos == m_cursor));
    endtask

    initial begin
        bus.sr_shift = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.sr_shift = ($urandom_range(1, 100) <= shift_pct);
        end
    end

    initial begin
        bus.line_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (auto_ack) begin
                if (bus.line_done) bus.line_done = 1'b0;
                else if (ack_delay == 0) begin
                    bus.line_done = 1'b1;
                    ack_delay     = -1;
                end else if (ack_delay > 0) ack_delay--;
                else if (bus.line_adv) ack_delay = $urandom_range(1, 5);
            end else begin
                bus.line_done = man_done;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                tb_pos = 0;
            end else begin
                if (bus.sr_shift && bus.sr_rc) begin
                    checks++;
                    if (exp_wr.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: pos %0d code %0d, required no write", tb_pos, bus.sr_din);
                    end else begin
                        mon_e = exp_wr.pop_front();
                        if (mon_e.col < 0) begin
                            chk("clear_code", int'(bus.sr_din), SPACE);
                            clr_hits[tb_pos]++;
                        end else begin
                            chk("write_col", tb_pos, mon_e.col);
                            chk("write_code", int'(bus.sr_din), int'(mon_e.code));
                        end
                    end
                end
                if (bus.line_adv) begin
                    checks++;
                    if (exp_adv_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_line_adv: line_adv=1 at pos %0d, required 0", tb_pos);
                    end else begin
                        void'(exp_adv_q.pop_front());
                    end
                end
                if (bus.sr_shift) tb_pos = (tb_pos == COLS - 1) ? 0 : tb_pos + 1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [6:0] bnd[5];
        int         n;
        bnd = '{7'h1F, 7'h20, 7'h5F, 7'h60, 7'h7F};
        bus.char_valid = 1'b0;
        bus.char_data  = 7'h00;
        bus.clr_req    = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        chk("reset_char_ready", int'(bus.char_ready), 1);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_sr_rc", int'(bus.sr_rc), 0);
        chk("reset_cursor_col", int'(bus.cursor_col), 0);
        chk("reset_line_adv", int'(bus.line_adv), 0);
        chk("reset_cursor_here", int'(bus.cursor_here), 1);

        repeat (40) cyc();
        chk("idle_cursor_col", int'(bus.cursor_col), 0);
        chk("idle_char_ready", int'(bus.char_ready), 1);
        chk("idle_pos_wrap", int'(bus.cursor_here), int'(tb_pos == 0));

        n = 0;
        while (tb_pos != 5 && n < 50) begin cyc(); n++; end
        send(7'h41);
        chk("a_busy", int'(bus.busy), 1);
        wait_idle();
        send(7'h61);
        wait_idle();
        send(7'h07);
        chk("bel_busy", int'(bus.busy), 0);
        chk("bel_cursor", int'(bus.cursor_col), 2);
        foreach (bnd[i]) send(bnd[i]);
        wait_idle();

        send(7'h0D);
        wait_idle();
        auto_ack = 1'b0;
        for (int i = 0; i < COLS; i++) send(7'($urandom_range(32, 127)));
        n = 0;
        while (exp_adv_q.size() != 0 && n < 500) begin cyc(); n++; end
        chk("wrap_line_adv_seen", exp_adv_q.size(), 0);
        repeat (10) cyc();
        chk("wrap_hold_busy", int'(bus.busy), 1);
        chk("wrap_hold_ready", int'(bus.char_ready), 0);
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        chk("wrap_ack_busy", int'(bus.busy), 0);
        wait_idle();

        for (int i = 0; i < 12; i++) send(7'($urandom_range(32, 127)));
        wait_idle();
        send(7'h0D);
        chk("cr_line_adv", int'(bus.line_adv), 1);
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        cyc();
        chk("cr_early_done_ignored", int'(bus.busy), 1);
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        chk("cr_ack_busy", int'(bus.busy), 0);
        auto_ack = 1'b1;
        wait_idle();

        send(7'h48);
        wait_idle();
        bus.clr_req    = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_data  = 7'h42;
        push_clear();
        cyc();
        bus.clr_req = 1'b0;
        chk("clr_busy", int'(bus.busy), 1);
        chk("clr_char_ready", int'(bus.char_ready), 0);
        n = 0;
        while (bus.busy && n < 500) begin cyc(); n++; end
        chk("clr_done_ready", int'(bus.char_ready), 1);
        chk("clr_done_cursor", int'(bus.cursor_col), 0);
        chk_hits("clr_hits");
        model_char(7'h42);
        cyc();
        bus.char_valid = 1'b0;
        chk("clr_pending_char_taken", int'(bus.busy), 1);
        wait_idle();

        shift_pct = 0;
        cyc();
        send(7'h43);
        cyc();
        chk("waitpos_hold", int'(bus.busy), 1);
        bus.clr_req = 1'b1;
        cyc();
        bus.clr_req = 1'b0;
        push_clear();
        shift_pct = 100;
        wait_idle();
        chk_hits("clr_after_write_hits");

        bus.clr_req = 1'b1;
        push_clear();
        cyc();
        bus.clr_req = 1'b0;
        repeat (10) cyc();
        bus.clr_req = 1'b1;
        cyc();
        bus.clr_req = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_wr.delete();
        m_cursor = 0;
        chk("rst_clr_busy", int'(bus.busy), 0);
        chk("rst_clr_sr_rc", int'(bus.sr_rc), 0);
        chk("rst_clr_cursor", int'(bus.cursor_col), 0);
        chk("rst_clr_ready", int'(bus.char_ready), 1);
        cyc();
        chk("rst_clr_pend_dropped", int'(bus.busy), 0);

        for (int it = 0; it < 200; it++) begin
            shift_pct = $urandom_range(20, 100);
            n = $urandom_range(0, 99);
            if (n < 5) begin
                if (n_clear() == 0) begin
                    bus.clr_req = 1'b1;
                    push_clear();
                    cyc();
                    bus.clr_req = 1'b0;
                end
            end else if (n < 15) begin
                send(7'h0D);
            end else if (n < 22) begin
                send(7'($urandom_range(0, 31)));
            end else begin
                send(7'($urandom_range(32, 127)));
            end
            if ($urandom_range(0, 9) == 0) wait_idle();
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/term_line_write_ctrl.md
Name: term_line_write_ctrl

Overview:
- Write sequencer for the 40-character recirculating line buffer (six 40-bit shift registers, one per character bit).
- Accepts ASCII characters from the keyboard/PIA side over a valid/ready handshake and tracks the column at the buffer tap.
- Drives the buffer's recirculate/load select so each character lands in the cursor column.
- Handles carriage return and auto-wrap by handing a line-advance request to the frame/scroll logic, and performs line clear.

Parameters:
- COLS, 40, characters per line; equals the shift-register depth.
- CW, 6, character code width stored in the buffer.
- SPACE, 6'h20, code written during clear.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- char_valid  input  1  character offered.
- char_data  input  7  ASCII character.
- char_ready  output  1  controller can accept a character this cycle.
- clr_req  input  1  one-cycle pulse: clear the current line.
- sr_shift  input  1  buffer advances one position this cycle.
- sr_rc  output  1  buffer input select: 1 = load sr_din, 0 = recirculate.
- sr_din  output  CW  code presented to the buffer input.
- line_adv  output  1  one-cycle pulse: request newline/scroll.
- line_done  input  1  frame logic finished the line advance.
- cursor_col  output  6  current cursor column, 0..COLS-1.
- cursor_here  output  1  pos == cursor_col; used for cursor display.
- busy  output  1  state != IDLE.

Behaviour:
- One clock, one edge. Reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- Reset values: state=IDLE, pos=0, cursor_col=0, clr_pend=0, char_reg=0, line_adv=0. sr_rc=0, char_ready=1, busy=0. Reset mid-write or mid-clear abandons the operation. Buffer contents are not touched.
- pos counter: increments on each sr_shift and wraps from COLS-1 to 0. It counts in every state.
- sr_rc and sr_din are combinational from registered state:
  - WAIT_POS: sr_rc = (pos==cursor_col), sr_din = char_reg.
  - CLEAR: sr_rc = 1, sr_din = SPACE.
  - All other states: sr_rc = 0, sr_din = char_reg.
- char_ready = (state==IDLE) && !clr_pend && !clr_req. A transfer happens when char_valid && char_ready.
- Character mapping on accept:
  - 0x0D (CR): go to NEWLINE.
  - Other codes below 0x20: discarded; stay in IDLE.
  - 0x20..0x5F: char_reg = data[5:0].
  - 0x60..0x7F: folded to upper case (data − 0x20), then low 6 bits.
  - Printable codes go to WAIT_POS.
- States and transitions:
  - IDLE: if clr_req or clr_pend, go to CLEAR (clear wins over a simultaneous char_valid). Else, on a transfer, go as mapped above.
  - WAIT_POS: on sr_shift with pos==cursor_col, the character is written that cycle.
    - If cursor_col == COLS-1, go to NEWLINE.
    - Else cursor_col += 1 and return to IDLE.
    - Worst-case wait: COLS sr_shift pulses.
  - NEWLINE: line_adv=1 for exactly one cycle (entry cycle), then go to WAIT_ACK.
  - WAIT_ACK: on line_done, cursor_col=0 and go to IDLE. line_done outside WAIT_ACK is ignored.
  - CLEAR:
    - On entry, clr_pend=0, a shift counter loads 0 and cursor_col=0.
    - Each sr_shift increments the counter. After COLS sr_shift pulses, go to IDLE.
    - Every buffer position is overwritten exactly once.
- clr_req arriving outside IDLE (including during CLEAR) sets clr_pend. It is served on the next return to IDLE and is never dropped.
- cursor_here = (pos==cursor_col) in all states.
- busy = (state != IDLE).

Test Plan:
- Reset, then 40 sr_shift pulses with no input -> sr_rc stays 0, pos wraps 39→0, cursor_col=0, char_ready=1.
- cursor_col=0, pos=5, offer 0x41 -> char accepted, busy=1. sr_rc=1 with sr_din=6'h01 only in the cycle where pos==0 and sr_shift=1, which is the 35th subsequent pulse. Then cursor_col=1, IDLE.
- Offer 0x61 -> sr_din=6'h01 (folded to 'A'). Offer 0x07 -> discarded, cursor_col unchanged, busy stays 0.
- Write 40 printable characters -> after the 40th write, line_adv pulses once. Hold line_done low for 10 cycles: still busy and char_ready=0. Assert line_done -> cursor_col=0, IDLE.
- cursor_col=12, offer 0x0D -> no sr_rc assertion, one line_adv pulse, then line_done -> cursor_col=0.
- clr_req with char_valid in the same cycle -> CLEAR taken and the char is not accepted. Exactly 40 sr_shift cycles with sr_rc=1 and sr_din=6'h20, then IDLE with cursor_col=0, and the pending char is accepted next.
- clr_req during WAIT_POS -> the write completes first, then CLEAR runs. Reset asserted mid-CLEAR -> next cycle IDLE, sr_rc=0, cursor_col=0, clr_pend=0.
